// File: rtl/controle_busca.sv
// controle_busca: instruction-fetch sequencer for the 8-bit processor.
// Owns the PC, addresses the asynchronous instruction ROM, and prefetches bytes
// into a small FIFO that feeds decode through a valid/ready handshake.
// Jumps flush the FIFO and refetch from the target. A halt level stops fetching.
// Optional feature macro: BUSCA_CONTADORES_EN adds the n_busca/n_bolha counters.
module controle_busca #(
    parameter int unsigned        ADDR_W     = 8,
    parameter int unsigned        DATA_W     = 8,
    parameter int unsigned        FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              halted
`ifdef BUSCA_CONTADORES_EN
    ,
    output logic [15:0]       n_busca,
    output logic [15:0]       n_bolha
`endif
);

    localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   fifo_pc   [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_inst [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W:0]      count;
    logic                fetch_en;
    logic                pop;
    logic                push;

    // The ROM is always addressed by the PC; mem_data is the byte at pc.
    assign mem_addr   = pc;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;
    // A full FIFO can still take a byte if the head leaves in the same cycle.
    assign push       = fetch_en & ~jump_en & ((count < DEPTH_C) | pop);
    assign inst       = inst_valid ? fifo_inst[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;

    // State register for the RUN/HALT sequencer.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // Next-state and fetch permission; halt blocks fetching in the cycle it is seen.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        fetch_en   = 1'b0;
        halted     = 1'b0;
        case (state)
            RUN: begin
                fetch_en = ~halt;
                if (halt) state_next = HALT;
            end
            HALT: begin
                halted = 1'b1;
                if (!halt) state_next = RUN;
            end
        endcase
    end

    // Program counter: redirect wins, otherwise advance on each fetched byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pc <= RESET_PC;
        else if (jump_en) pc <= jump_addr;
        else if (push)    pc <= pc + 1'b1;
    end

    // FIFO payload storage, written at the tail on push.
    // NOTE: the storage array has no reset; validity comes only from count,
    // so stale entries are never visible and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= pc;
            fifo_inst[wr_ptr] <= mem_data;
        end
    end

    // FIFO pointers and occupancy; a redirect discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (jump_en) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

`ifdef BUSCA_CONTADORES_EN
    // Saturating statistics: bytes fetched, and RUN cycles with nothing for decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_busca <= '0;
            n_bolha <= '0;
        end else begin
            if (push && (n_busca != 16'hFFFF))
                n_busca <= n_busca + 16'd1;
            if ((state == RUN) && !inst_valid && (n_bolha != 16'hFFFF))
                n_bolha <= n_bolha + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_controle_busca.sv
// Bench for controle_busca: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_controle_busca;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] inst;
    logic [7:0] inst_pc;
    logic       inst_valid;
    logic       inst_ready;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       halt;
    logic       halted;
`ifdef BUSCA_CONTADORES_EN
    logic [15:0] n_busca;
    logic [15:0] n_bolha;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: queued {pc, byte} entries, fetch pointer, run flag.
    logic [15:0] mq[$];
    logic [7:0]  m_pc;
    logic        m_run;
    int          m_busca;
    int          m_bolha;

    typedef struct packed {
        logic       r;
        logic       j;
        logic [7:0] ja;
        logic       v;
        logic [7:0] pc;
        logic [7:0] ins;
        logic [7:0] ma;
    } vec_t;

    vec_t tbl[11];

    always #5 clk = ~clk;

    // ROM preloaded with mem[i] = i ^ 8'hA5.
    assign mem_data = mem_addr ^ 8'hA5;

    controle_busca dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .halt       (halt),
        .halted     (halted)
`ifdef BUSCA_CONTADORES_EN
        ,
        .n_busca    (n_busca),
        .n_bolha    (n_bolha)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 8'h00;
        m_run   = 1'b1;
        m_busca = 0;
        m_bolha = 0;
    endtask

    // One clock edge of the fetch rules applied to the queue model.
    task automatic model_edge(input logic r, input logic j, input logic [7:0] ja, input logic h);
        bit do_pop;
        bit do_push;
        do_pop  = (mq.size() != 0) && r;
        do_push = m_run && !h && !j && ((mq.size() < DEPTH) || do_pop);
        if (m_run && (mq.size() == 0)) m_bolha++;
        if (do_pop) void'(mq.pop_front());
        if (j) begin
            mq.delete();
            m_pc = ja;
        end else if (do_push) begin
            mq.push_back({m_pc, m_pc ^ 8'hA5});
            m_pc = m_pc + 8'd1;
            m_busca++;
        end
        m_run = !h;
    endtask

    task automatic check_model(input string name);
        logic       ev;
        logic [7:0] ep;
        logic [7:0] ei;
        ev = (mq.size() != 0);
        ep = ev ? mq[0][15:8] : 8'h00;
        ei = ev ? mq[0][7:0]  : 8'h00;
        check(name, {6'd0, inst_valid, inst_pc, inst, mem_addr, halted},
                    {6'd0, ev, ep, ei, m_pc, !m_run});
    endtask

    // Drive inputs at the falling edge, advance one cycle, compare at the next falling edge.
    task automatic step(input logic r, input logic j, input logic [7:0] ja, input logic h);
        inst_ready = r;
        jump_en    = j;
        jump_addr  = ja;
        halt       = h;
        @(posedge clk);
        model_edge(r, j, ja, h);
        @(negedge clk);
        check_model("model");
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        inst_ready = 1'b0;
        jump_en    = 1'b0;
        jump_addr  = 8'h00;
        halt       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check("rst_valid",   {31'd0, inst_valid}, 32'd0);
        check("rst_inst_pc", {24'd0, inst_pc},    32'd0);
        check("rst_inst",    {24'd0, inst},       32'd0);
        check("rst_halted",  {31'd0, halted},     32'd0);
        check("rst_addr",    {24'd0, mem_addr},   32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic       h;
        logic [7:0] held;

        // Directed table from reset: streaming, backpressure, redirect to 0x40.
        tbl[0]  = '{r:1'b1, j:1'b0, ja:8'h00, v:1'b1, pc:8'h00, ins:8'hA5, ma:8'h01};
        tbl[1]  = '{r:1'b1, j:1'b0, ja:8'h00, v:1'b1, pc:8'h01, ins:8'hA4, ma:8'h02};
        tbl[2]  = '{r:1'b1, j:1'b0, ja:8'h00, v:1'b1, pc:8'h02, ins:8'hA7, ma:8'h03};
        tbl[3]  = '{r:1'b0, j:1'b0, ja:8'h00, v:1'b1, pc:8'h02, ins:8'hA7, ma:8'h04};
        tbl[4]  = '{r:1'b0, j:1'b0, ja:8'h00, v:1'b1, pc:8'h02, ins:8'hA7, ma:8'h04};
        tbl[5]  = '{r:1'b0, j:1'b0, ja:8'h00, v:1'b1, pc:8'h02, ins:8'hA7, ma:8'h04};
        tbl[6]  = '{r:1'b1, j:1'b0, ja:8'h00, v:1'b1, pc:8'h03, ins:8'hA6, ma:8'h05};
        tbl[7]  = '{r:1'b1, j:1'b0, ja:8'h00, v:1'b1, pc:8'h04, ins:8'hA1, ma:8'h06};
        tbl[8]  = '{r:1'b1, j:1'b1, ja:8'h40, v:1'b0, pc:8'h00, ins:8'h00, ma:8'h40};
        tbl[9]  = '{r:1'b1, j:1'b0, ja:8'h00, v:1'b1, pc:8'h40, ins:8'hE5, ma:8'h41};
        tbl[10] = '{r:1'b1, j:1'b0, ja:8'h00, v:1'b1, pc:8'h41, ins:8'hE4, ma:8'h42};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            inst_ready = tbl[i].r;
            jump_en    = tbl[i].j;
            jump_addr  = tbl[i].ja;
            halt       = 1'b0;
            @(posedge clk);
            model_edge(tbl[i].r, tbl[i].j, tbl[i].ja, 1'b0);
            @(negedge clk);
            check($sformatf("tbl%0d", i),
                  {6'd0, inst_valid, inst_pc, inst, mem_addr, halted},
                  {6'd0, tbl[i].v, tbl[i].pc, tbl[i].ins, tbl[i].ma, 1'b0});
        end

        // Backpressure from reset: FIFO fills to two, address holds at 2, then drains in order.
        do_reset();
        repeat (5) step(1'b0, 1'b0, 8'h00, 1'b0);
        check("bp_addr_hold", {24'd0, mem_addr}, 32'h02);
        check("bp_head0",     {24'd0, inst_pc},  32'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("bp_head1", {24'd0, inst_pc}, 32'h01);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("bp_head2", {24'd0, inst_pc}, 32'h02);

        // Redirect near the top of the address space: FE, FF, 00, 01.
        step(1'b1, 1'b1, 8'hFE, 1'b0);
        check("jmp_bubble", {31'd0, inst_valid}, 32'd0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("wrap_fe", {24'd0, inst_pc}, 32'hFE);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("wrap_ff", {24'd0, inst_pc}, 32'hFF);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("wrap_00", {24'd0, inst_pc}, 32'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("wrap_01", {24'd0, inst_pc}, 32'h01);

        // Halt with two queued: both drain, then idle with the address frozen.
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        held = mem_addr;
        repeat (4) step(1'b1, 1'b0, 8'h00, 1'b1);
        check("halt_halted", {31'd0, halted},     32'd1);
        check("halt_empty",  {31'd0, inst_valid}, 32'd0);
        check("halt_addr",   {24'd0, mem_addr},   {24'd0, held});
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("resume_pc", {24'd0, inst_pc}, {24'd0, held});

        // Redirect together with halt: target taken, then halted with nothing fetched.
        step(1'b1, 1'b1, 8'h80, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("jmp_halt_addr", {24'd0, mem_addr}, 32'h80);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("jmp_halt_resume", {24'd0, inst_pc}, 32'h80);

        // Asynchronous reset between edges clears the output immediately.
        step(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, inst_valid}, 32'd0);
        check("async_addr",  {24'd0, mem_addr},   32'h00);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("post_rst_pc", {24'd0, inst_pc}, 32'h00);

        // Randomized traffic against the model.
        h = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic       j;
            logic [7:0] ja;
            r  = ($urandom_range(3) != 0);
            j  = ($urandom_range(15) == 0);
            ja = ($urandom_range(3) == 0) ? 8'(8'hF8 + $urandom_range(7)) : 8'($urandom);
            if ($urandom_range(9) == 0) h = ~h;
            step(r, j, ja, h);
        end

`ifdef BUSCA_CONTADORES_EN
        check("n_busca", {16'd0, n_busca}, {16'd0, m_busca[15:0]});
        check("n_bolha", {16'd0, n_bolha}, {16'd0, m_bolha[15:0]});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
